fp_minmax_reduce: RTL and testbench
===================================

# fp_minmax_reduce

Streaming, parametrised floating-point min/max reduction unit for the FPU. It accepts a vector of up to `MAX_LEN` sign-magnitude floats, one per handshake beat. It returns the minimum or maximum element and that element's index. NaN handling and a strict total order on signed zeros are built in. It sits beside the FPU datapath and serves vector-reduce instructions, replacing per-element software loops over the scalar two-operand min/max.

## Interface
Parameters:
- `EXP_W`, 8, exponent width (default bf16).
- `MAN_W`, 7, mantissa width; element width `W = 1 + EXP_W + MAN_W`.
- `MAX_LEN`, 32, maximum vector length (>= 1).
- `LEN_W` (derived) = `$clog2(MAX_LEN+1)`; `IDX_W` (derived) = max(1, `$clog2(MAX_LEN)`).

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begin a reduction (sampled only in IDLE).
- `mode_i`  in  1  0 = min, 1 = max; captured with `start_i`.
- `len_i`  in  LEN_W  element count; captured with `start_i`.
- `in_valid_i`  in  1  element valid.
- `in_ready_o`  out  1  element accepted when `in_valid_i & in_ready_o`.
- `in_data_i`  in  W  element.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  result consumed when `out_valid_o & out_ready_i`.
- `out_data_o`  out  W  selected element (or canonical NaN).
- `out_idx_o`  out  IDX_W  zero-based index of selected element.
- `out_nan_o`  out  1  no non-NaN element was seen.
- `busy_o`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
  - IDLE -> ACCUM on `start_i` with captured len != 0.
  - IDLE -> DONE on `start_i` with len == 0.
  - ACCUM -> DONE on the beat that accepts element `len-1`.
  - DONE -> IDLE on output handshake.
- Captured len values above `MAX_LEN` are clamped to `MAX_LEN`.
- `start_i` outside IDLE is ignored. `in_valid_i` outside ACCUM is ignored.
- NaN detection: exponent all ones and mantissa != 0. Canonical NaN is sign 0, exponent all ones, mantissa MSB 1, remaining mantissa bits 0 (bf16: 0x7FC0).
- Ordering of non-NaN values (a < b):
  - negative < positive, so -0 < +0.
  - Both positive: smaller magnitude (bits [W-2:0]) is less.
  - Both negative: larger magnitude is less.
  - Infinities order naturally under these rules.
- Accumulator: registers `acc_data`, `acc_idx`, `acc_nan` (set to 1 on `start_i`) and a beat counter `cnt`.
- On each accepted beat, with element `x` at index `cnt`:
  - `x` NaN: no update.
  - `x` non-NaN and `acc_nan` = 1: load `x` and `cnt`; clear `acc_nan`.
  - `x` non-NaN and `acc_nan` = 0: replace if `x < acc` (min mode) or `acc < x` (max mode). Replacement is strict, so ties keep the earlier index.
- In DONE:
  - `acc_nan` = 1 (all elements NaN, or len == 0): `out_data_o` = canonical NaN, `out_idx_o` = 0, `out_nan_o` = 1.
  - Otherwise: `out_data_o` = `acc_data` exactly as received (sign and payload unchanged), `out_idx_o` = `acc_idx`, `out_nan_o` = 0.

## Timing
- Reset values: state IDLE, `in_ready_o` = 0, `out_valid_o` = 0, `busy_o` = 0, `out_data_o` = 0, `out_idx_o` = 0, `out_nan_o` = 0.
- `rst_i` asserted in any state returns the block to IDLE next cycle with the values above. A partial reduction is discarded and produces no output.
- `in_ready_o` = 1 exactly while in ACCUM. Throughput is one element per cycle, and `in_valid_i` bubbles are tolerated.
- Latency:
  - `out_valid_o` rises the cycle after the last input handshake.
  - For len == 0, `out_valid_o` rises the cycle after `start_i`.
- Outputs are registered. `out_data_o`, `out_idx_o` and `out_nan_o` are stable while `out_valid_o` = 1 and `out_ready_i` = 0.
- `start_i` is accepted in the cycle after the output handshake (IDLE), not in the handshake cycle itself.
- `busy_o` is high from the cycle after `start_i` until the cycle after the output handshake.

## Test plan
- Min, len 4, inputs 0x3F80, 0xBF80, 0x4000, 0xBF80 -> out 0xBF80, idx 1 (tie keeps first), nan 0; `out_valid_o` one cycle after beat 3.
- Max, len 3, inputs 0x8000, 0x0000, 0x8000 -> out 0x0000, idx 1. Min on the same inputs -> 0x8000, idx 0.
- Min, len 3, inputs 0x7FC1, 0x4000, 0xFF81 -> out 0x4000, idx 1, nan 0. All-NaN inputs -> out 0x7FC0, idx 0, nan 1. len 0 -> same canonical NaN result, one cycle after `start_i`.
- Max, len 5 with `in_valid_i` toggling every other cycle and `out_ready_i` held low 3 cycles -> result 0x7F80 (+inf at idx 2) is held stable until consumed; `start_i` pulsed during ACCUM is ignored.
- `rst_i` asserted after 2 of 4 beats -> `busy_o` = 0 and `in_ready_o` = 0 next cycle, no `out_valid_o`. A new len-1 reduction of 0xC040 then yields out 0xC040, idx 0.
- `len_i` = `MAX_LEN`+5 with `MAX_LEN` = 32 -> exactly 32 beats accepted; max of ascending 0x3F80 + i returns idx 31.

Source files
------------

// File: rtl/fp_minmax_reduce_if.sv
// Handshake and result bus of the streaming FP min/max reduction unit.
// The slave modport is the reduction unit's view. The master modport is the requester's view.
interface fp_minmax_reduce_if #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 7,
    parameter int MAX_LEN = 32
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic             start_i;
    logic             mode_i;
    logic [LEN_W-1:0] len_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [W-1:0]     in_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [W-1:0]     out_data_o;
    logic [IDX_W-1:0] out_idx_o;
    logic             out_nan_o;
    logic             busy_o;

    modport slave (
        input  start_i, mode_i, len_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_idx_o, out_nan_o, busy_o
    );

    modport master (
        output start_i, mode_i, len_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_idx_o, out_nan_o, busy_o
    );
endinterface

// File: rtl/fp_minmax_reduce.sv
// Streaming min/max reduction over up to MAX_LEN sign-magnitude floats.
// NaNs are skipped. Zeros follow a strict total order in which -0 < +0.
// On a tie, the element with the earlier index is kept.
module fp_minmax_reduce #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 7,
    parameter int MAX_LEN = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    fp_minmax_reduce_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
    localparam logic [W-1:0]     QNAN    = W'({(EXP_W + 1){1'b1}}) << (MAN_W - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic             mode_q;
    logic [LEN_W-1:0] len_q, cnt_q;
    logic [W-1:0]     acc_data_q, nxt_data;
    logic [IDX_W-1:0] acc_idx_q, nxt_idx;
    logic             acc_nan_q, nxt_nan;
    logic [W-1:0]     out_data_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_nan_q;
    logic             start_go, beat, last, load_zero;
    logic [LEN_W-1:0] len_cap;

    function automatic logic is_nan(input logic [W-1:0] v);
        return (&v[W-2:MAN_W]) && (|v[MAN_W-1:0]);
    endfunction

    // Strict a < b for non-NaN sign-magnitude values.
    function automatic logic less(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a[W-1] != b[W-1]) return a[W-1];
        if (!a[W-1])          return a[W-2:0] < b[W-2:0];
        return a[W-2:0] > b[W-2:0];
    endfunction

    // Decode the handshakes and fold the incoming element into the running result.
    always_comb begin
        start_go  = (state_q == IDLE) && bus.start_i;
        len_cap   = (bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;
        load_zero = start_go && (len_cap == '0);
        beat      = (state_q == ACCUM) && bus.in_valid_i;
        last      = beat && (cnt_q == len_q - LEN_W'(1));
        nxt_data  = acc_data_q;
        nxt_idx   = acc_idx_q;
        nxt_nan   = acc_nan_q;
        if (!is_nan(bus.in_data_i)) begin
            if (acc_nan_q || (mode_q ? less(acc_data_q, bus.in_data_i)
                                     : less(bus.in_data_i, acc_data_q))) begin
                nxt_data = bus.in_data_i;
                nxt_idx  = cnt_q[IDX_W-1:0];
                nxt_nan  = 1'b0;
            end
        end
    end

    // Next-state logic for the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = (len_cap == '0) ? DONE : ACCUM;
            ACCUM:   if (last) state_d = DONE;
            DONE:    if (bus.out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Hold the state, the accumulator and the registered result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            acc_data_q <= '0;
            acc_idx_q  <= '0;
            acc_nan_q  <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_nan_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_go) begin
                mode_q    <= bus.mode_i;
                len_q     <= len_cap;
                cnt_q     <= '0;
                acc_nan_q <= 1'b1;
            end
            if (beat) begin
                cnt_q      <= cnt_q + LEN_W'(1);
                acc_data_q <= nxt_data;
                acc_idx_q  <= nxt_idx;
                acc_nan_q  <= nxt_nan;
            end
            // Capture the result on the way into DONE. Updates from the final beat are included.
            if (load_zero || (last && nxt_nan)) begin
                out_data_q <= QNAN;
                out_idx_q  <= '0;
                out_nan_q  <= 1'b1;
            end else if (last) begin
                out_data_q <= nxt_data;
                out_idx_q  <= nxt_idx;
                out_nan_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o  = (state_q == ACCUM);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.out_data_o  = out_data_q;
    assign bus.out_idx_o   = out_idx_q;
    assign bus.out_nan_o   = out_nan_q;
endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Directed bench for fp_minmax_reduce (bf16, MAX_LEN = 32).
module tb_fp_minmax_reduce;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fp_minmax_reduce_if #(.EXP_W(8), .MAN_W(7), .MAX_LEN(32)) bus ();

    fp_minmax_reduce #(.EXP_W(8), .MAN_W(7), .MAX_LEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after it was sampled.
    task automatic start_red(input logic m, input int l);
        bus.start_i = 1'b1;
        bus.mode_i  = m;
        bus.len_i   = 6'(l);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Present one element; returns at the negedge after it was accepted.
    task automatic send(input logic [15:0] x);
        int t = 0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = x;
        while (!bus.in_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
    endtask

    // Wait for the result, check it, consume it, then confirm the unit went idle.
    task automatic expect_res(input string tag, input logic [15:0] d, input logic [4:0] i,
                              input logic n);
        int t = 0;
        while (!bus.out_valid_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
        chk({tag, "_data"}, 32'(bus.out_data_o), 32'(d));
        chk({tag, "_idx"}, 32'(bus.out_idx_o), 32'(i));
        chk({tag, "_nan"}, 32'(bus.out_nan_o), 32'(n));
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        chk({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        logic [15:0] v [5];

        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.mode_i      = 1'b0;
        bus.len_i       = '0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_data", 32'(bus.out_data_o), 32'd0);
        chk("rst_idx", 32'(bus.out_idx_o), 32'd0);
        chk("rst_nan", 32'(bus.out_nan_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Min, with a tie on -1.0: the first occurrence wins
        start_red(1'b0, 4);
        chk("min4_busy", 32'(bus.busy_o), 32'd1);
        chk("min4_ready", 32'(bus.in_ready_o), 32'd1);
        send(16'h3F80); send(16'hBF80); send(16'h4000);
        chk("min4_early", 32'(bus.out_valid_o), 32'd0);
        send(16'hBF80);
        chk("min4_latency", 32'(bus.out_valid_o), 32'd1);
        expect_res("min4", 16'hBF80, 5'd1, 1'b0);

        // Signed zeros
        start_red(1'b1, 3);
        send(16'h8000); send(16'h0000); send(16'h8000);
        expect_res("max_zero", 16'h0000, 5'd1, 1'b0);
        start_red(1'b0, 3);
        send(16'h8000); send(16'h0000); send(16'h8000);
        expect_res("min_zero", 16'h8000, 5'd0, 1'b0);

        // NaN skipping, all-NaN input, and zero length
        start_red(1'b0, 3);
        send(16'h7FC1); send(16'h4000); send(16'hFF81);
        expect_res("min_nan", 16'h4000, 5'd1, 1'b0);
        start_red(1'b1, 3);
        send(16'h7FC1); send(16'hFF81); send(16'h7F81);
        expect_res("all_nan", 16'h7FC0, 5'd0, 1'b1);
        start_red(1'b0, 0);
        chk("len0_latency", 32'(bus.out_valid_o), 32'd1);
        expect_res("len0", 16'h7FC0, 5'd0, 1'b1);

        // Max with bubbles, a stray start, and output backpressure
        v = '{16'h3F80, 16'hFF80, 16'h7F80, 16'h4000, 16'h7F80};
        start_red(1'b1, 5);
        for (int k = 0; k < 5; k++) begin
            send(v[k]);
            if (k < 4) begin
                if (k == 1) begin
                    bus.start_i = 1'b1;
                    bus.mode_i  = 1'b0;
                    bus.len_i   = 6'd1;
                end
                @(negedge clk);
                bus.start_i = 1'b0;
            end
        end
        chk("bub_latency", 32'(bus.out_valid_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bub_hold_valid", 32'(bus.out_valid_o), 32'd1);
            chk("bub_hold_data", 32'(bus.out_data_o), 32'h7F80);
            chk("bub_hold_idx", 32'(bus.out_idx_o), 32'd2);
        end
        // A start presented in the handshake cycle must be ignored.
        bus.out_ready_i = 1'b1;
        bus.start_i     = 1'b1;
        bus.len_i       = 6'd0;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        bus.start_i     = 1'b0;
        chk("hs_busy", 32'(bus.busy_o), 32'd0);
        chk("hs_valid", 32'(bus.out_valid_o), 32'd0);
        @(negedge clk);
        chk("hs_start_ignored", 32'(bus.busy_o), 32'd0);

        // Reset mid-reduction
        start_red(1'b0, 4);
        send(16'h3F80); send(16'h4000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_no_out", 32'(bus.out_valid_o), 32'd0);
            @(negedge clk);
        end
        start_red(1'b0, 1);
        send(16'hC040);
        expect_res("after_rst", 16'hC040, 5'd0, 1'b0);

        // Length clamp: 37 requested, 32 accepted
        start_red(1'b1, 37);
        for (int k = 0; k < 32; k++) send(16'h3F80 + 16'(k));
        chk("clamp_ready", 32'(bus.in_ready_o), 32'd0);
        chk("clamp_valid", 32'(bus.out_valid_o), 32'd1);
        expect_res("clamp", 16'h3F9F, 5'd31, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
